exc_cp0_ctrl: RTL

Parameterised exception and pipeline controller for the 5-stage MIPS32 core.
- Merges CP0 (Count, Compare, Status, Cause, EPC) with stall/flush generation.
- Prioritises external interrupts, syscall and eret for the instruction in MEM.
- Drives per-stage stall/flush vectors and the redirect PC into IF.

---
 rtl/exc_cp0_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/exc_cp0_ctrl.sv
// exc_cp0_ctrl: exception and pipeline controller for the 5-stage MIPS32 core.
// It holds the CP0 registers (Count, Compare, Status, Cause, EPC). It picks
// which interrupt, syscall or eret the MEM-stage instruction takes, and it
// drives the per-stage stall/flush vectors and the redirect PC into IF.
//
// Optional build macro: TIMER_IRQ_EN
//   Defined  : Count runs freely. Count==Compare latches Cause.IP[7]
//              (sticky), and a write to Compare clears it.
//   Undefined: Count and Compare read 0 and ignore writes.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   irq_in             level-sensitive external interrupts -> Cause.IP[i+2]
//   mem_valid, mem_pc  MEM-stage instruction valid and its PC
//   exc_syscall/eret   MEM instruction is syscall / eret
//   exc_delay          MEM instruction sits in a delay slot
//   stallreq_id/ex     stall requests from ID and EX
//   cp0_we/waddr/wdata mtc0 write from WB
//   cp0_raddr/rdata    mfc0 read port (combinational, with WB bypass)
//   stall_o, flush_o   {MEWB,EXME,IDEX,IFID,PC} hold / flush enables
//   exc_pc             redirect target, valid while flush_o[0]=1
//   status_o, epc_o    current Status and EPC
module exc_cp0_ctrl #(
  parameter int unsigned NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] RST_STATUS = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mem_valid,
  input  logic [31:0]        mem_pc,
  input  logic               exc_syscall,
  input  logic               exc_eret,
  input  logic               exc_delay,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_waddr,
  input  logic [31:0]        cp0_wdata,
  input  logic [4:0]         cp0_raddr,
  output logic [31:0]        cp0_rdata,
  output logic [4:0]         stall_o,
  output logic [4:0]         flush_o,
  output logic [31:0]        exc_pc,
  output logic [31:0]        status_o,
  output logic [31:0]        epc_o
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_ip_q, timer_ip_d;

  logic [7:0]  cause_ip;
  logic [31:0] cause_rd;
  logic        int_pend, take_int, take_sys, take_eret, take_exc, take_any;
  logic        we_ok;

  always_comb begin
    ip_hw_d = '0;
    ip_hw_d[NUM_IRQ-1:0] = irq_in;
  end

`ifdef TIMER_IRQ_EN
  // When all six lines exist, the timer takes over IP[7] from irq_in[5].
  assign cause_ip = {(NUM_IRQ == 6) ? timer_ip_q : (timer_ip_q | ip_hw_q[5]),
                     ip_hw_q[4:0], ip_sw_q};
`else
  assign cause_ip = {ip_hw_q, ip_sw_q};
`endif

  assign cause_rd = {bd_q, 15'b0, cause_ip, 1'b0, exccode_q, 2'b0};

  assign int_pend  = mem_valid & status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_ip));
  assign take_int  = (state_q == S_RUN) & int_pend;
  assign take_sys  = (state_q == S_RUN) & mem_valid & exc_syscall & ~int_pend;
  assign take_eret = (state_q == S_RUN) & mem_valid & exc_eret & ~int_pend & ~exc_syscall;
  assign take_exc  = take_int | take_sys;
  assign take_any  = take_exc | take_eret;

  // An exception edge owns the registers it updates, so a same-cycle mtc0 to
  // one of them is dropped as a whole.
  assign we_ok = cp0_we
               & ~(take_exc  & (cp0_waddr == REG_STATUS || cp0_waddr == REG_CAUSE ||
                                cp0_waddr == REG_EPC))
               & ~(take_eret & (cp0_waddr == REG_STATUS));

  always_comb begin
    state_d    = take_any ? S_FLUSH : S_RUN;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    count_d    = '0;
    compare_d  = '0;
    timer_ip_d = 1'b0;
`ifdef TIMER_IRQ_EN
    count_d    = count_q + 32'd1;
    compare_d  = compare_q;
    timer_ip_d = timer_ip_q | (count_q == compare_q);
    if (we_ok && cp0_waddr == REG_COUNT) count_d = cp0_wdata;
    if (we_ok && cp0_waddr == REG_COMPARE) begin
      compare_d  = cp0_wdata;
      timer_ip_d = 1'b0;
    end
`endif
    if (we_ok) begin
      case (cp0_waddr)
        REG_STATUS: status_d = cp0_wdata & STATUS_MASK;
        REG_CAUSE:  ip_sw_d  = cp0_wdata[9:8];
        REG_EPC:    epc_d    = cp0_wdata;
        default: ;
      endcase
    end
    if (take_exc) begin
      epc_d       = exc_delay ? mem_pc - 32'd4 : mem_pc;
      bd_d        = exc_delay;
      exccode_d   = take_int ? 5'd0 : 5'd8;
      status_d[1] = 1'b1;
    end else if (take_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      status_q   <= RST_STATUS & STATUS_MASK;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      timer_ip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      timer_ip_q <= timer_ip_d;
    end
  end

  always_comb begin
    stall_o = '0;
    flush_o = '0;
    exc_pc  = '0;
    if (rst) begin
      flush_o = 5'b11111;
    end else if (take_any) begin
      flush_o = 5'b11111;
      exc_pc  = take_eret ? epc_q : EXC_VECTOR;
    end else if (state_q == S_RUN) begin
      if (stallreq_ex) begin
        stall_o = 5'b00111;
        flush_o = 5'b01000;
      end else if (stallreq_id) begin
        stall_o = 5'b00011;
        flush_o = 5'b00100;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    if (!rst) begin
      if (cp0_we && cp0_waddr == cp0_raddr) begin
        case (cp0_raddr)
          REG_STATUS: cp0_rdata = cp0_wdata & STATUS_MASK;
          REG_CAUSE:  cp0_rdata = {cause_rd[31:10], cp0_wdata[9:8], cause_rd[7:0]};
          REG_EPC:    cp0_rdata = cp0_wdata;
`ifdef TIMER_IRQ_EN
          REG_COUNT, REG_COMPARE: cp0_rdata = cp0_wdata;
`endif
          default: cp0_rdata = '0;
        endcase
      end else begin
        case (cp0_raddr)
          REG_STATUS:  cp0_rdata = status_q;
          REG_CAUSE:   cp0_rdata = cause_rd;
          REG_EPC:     cp0_rdata = epc_q;
          REG_COUNT:   cp0_rdata = count_q;
          REG_COMPARE: cp0_rdata = compare_q;
          default:     cp0_rdata = '0;
        endcase
      end
    end
  end

  assign status_o = status_q;
  assign epc_o    = epc_q;

endmodule
